// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg
//   Shared types and helpers for the truth-table sweeper.
//   - state_e         : sweeper FSM states (IDLE, RUN, DONE)
//   - MODE_*          : sweep-order encodings carried on the 2-bit mode port
//   - tts_map_pattern : maps a sweep index and mode to the stimulus pattern
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BIN_UP   = 2'd0;
  localparam logic [1:0] MODE_GRAY     = 2'd1;
  localparam logic [1:0] MODE_BIN_DOWN = 2'd2;

  // Computed at the widest supported N_IN (16). The index is zero-extended,
  // so the low N_IN bits are correct for every mapping. Callers truncate the
  // result to N_IN bits. Mode 3 falls through to binary up.
  function automatic logic [15:0] tts_map_pattern(input logic [15:0] idx,
                                                  input logic [1:0]  mode);
    case (mode)
      MODE_GRAY:     return idx ^ (idx >> 1);
      MODE_BIN_DOWN: return ~idx;
      default:       return idx;
    endcase
  endfunction

endpackage

// File: rtl/tts_pattern_gen.sv
// tts_pattern_gen
//   Sweep index, per-pattern hold counter and registered stimulus pattern.
//   Ports:
//     clk_i, rst_ni  : clock, asynchronous active-low reset
//     load_i         : accepted start; restarts the sweep at index 0
//     run_i          : sweeper is in RUN
//     mode_i         : sweep order to apply (already latched/selected)
//     x_o            : registered stimulus pattern
//     sample_stb_o   : last hold cycle of the current pattern
//     last_o         : current index is the final pattern of the sweep
module tts_pattern_gen
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            run_i,
  input  logic [1:0]      mode_i,
  output logic [N_IN-1:0] x_o,
  output logic            sample_stb_o,
  output logic            last_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [N_IN-1:0]   index_q, index_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_IN-1:0]   index_nxt;

  assign sample_stb_o = run_i && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign last_o       = &index_q;
  assign index_nxt    = index_q + N_IN'(1);
  assign x_o          = x_q;

  always_comb begin
    index_d = index_q;
    hold_d  = hold_q;
    x_d     = x_q;
    if (load_i) begin
      index_d = '0;
      hold_d  = '0;
      x_d     = N_IN'(tts_map_pattern('0, mode_i));
    end else if (run_i) begin
      if (sample_stb_o) begin
        hold_d = '0;
        // On the final pattern x is left alone so it holds through DONE.
        if (!last_o) begin
          index_d = index_nxt;
          x_d     = N_IN'(tts_map_pattern(16'(index_nxt), mode_i));
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= '0;
      hold_q  <= '0;
      x_q     <= '0;
    end else begin
      index_q <= index_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Sweeps every input combination of a combinational DUT, holding each
//   pattern HOLD_CYCLES cycles, and checks y against y_inv on the last hold
//   cycle. Counts failing patterns and captures the first failing pattern.
//   Optional build macro: TTS_SIGNATURE_EN adds an N_OUT-bit MISR over y.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     start, mode     : sweep request and sweep order (0 up, 1 Gray, 2 down)
//     x               : stimulus to the DUT
//     y, y_inv        : DUT true / complement outputs
//     busy, done      : sweep in progress / sweep finished
//     sample_stb      : cycle on which y/y_inv are checked
//     err_count       : saturating count of failing patterns
//     first_err_valid : a failure was recorded this sweep
//     first_err_pat   : x of the first failing pattern
//     signature       : MISR result (0 when TTS_SIGNATURE_EN is undefined)
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] y,
  input  logic [N_OUT-1:0] y_inv,
  output logic             busy,
  output logic             done,
  output logic             sample_stb,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_pat,
  output logic [N_OUT-1:0] signature
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [N_IN-1:0]  fep_q, fep_d;

  logic             accept;
  logic             last_pat;
  logic             fail;
  logic [1:0]       mode_eff;

  // start is only honoured outside RUN.
  assign accept   = start && (state_q != RUN);
  // The generator must see the new mode on the accepting edge itself.
  assign mode_eff = accept ? mode : mode_q;
  assign fail     = sample_stb && ((y ^ y_inv) != '1);

  tts_pattern_gen #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_gen (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (accept),
    .run_i        (state_q == RUN),
    .mode_i       (mode_eff),
    .x_o          (x),
    .sample_stb_o (sample_stb),
    .last_o       (last_pat)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fep_d   = fep_q;
    if (accept) begin
      state_d = RUN;
      mode_d  = mode;
      err_d   = '0;
      fev_d   = 1'b0;
      fep_d   = '0;
    end else if (state_q == RUN) begin
      if (fail) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (!fev_q) begin
          fev_d = 1'b1;
          fep_d = x;
        end
      end
      if (sample_stb && last_pat) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_BIN_UP;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fep_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fep_q   <= fep_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_pat   = fep_q;

`ifdef TTS_SIGNATURE_EN
  logic [N_OUT-1:0] sig_q, sig_d;
  logic [N_OUT-1:0] sig_shift;

  if (N_OUT == 1) begin : g_sig_1
    assign sig_shift = '0;
  end else begin : g_sig_n
    assign sig_shift = {sig_q[N_OUT-2:0], sig_q[N_OUT-1]};
  end

  always_comb begin
    sig_d = sig_q;
    if (accept)          sig_d = '0;
    else if (sample_stb) sig_d = sig_shift ^ y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule
